// File: rtl/rc4_core_arbiter.sv
// Round-robin arbiter sharing one RC4 keystream core between NUM_REQ requesters.
// Optional RUN watchdog enabled by defining RC4_TIMEOUT_EN.
module rc4_core_arbiter #(
    parameter int NUMS_OF_BYTES  = 4,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*32-1:0]      req_key,
    input  logic [NUM_REQ*8-1:0]       req_key_length,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [NUMS_OF_BYTES*8-1:0] rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       core_start,
    output logic [31:0]                core_key,
    output logic [7:0]                 core_key_length,
    input  logic                       core_done,
    input  logic [NUMS_OF_BYTES*8-1:0] core_ks
);

    // state | meaning
    // IDLE  | arbitrate among pending requests
    // RUN   | core working, waiting for core_done
    // RESP  | response held for the owner until rsp_ready
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     win;
    logic              found;
    logic [31:0]       sel_key;
    logic [7:0]        sel_len;
    logic              legal;
    logic [PW-1:0]     next_ptr;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] owner_oh;

    // Rotating search: first pending requester at or after rr_ptr wins.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign sel_key  = req_key[32*win +: 32];
    assign sel_len  = req_key_length[8*win +: 8];
    assign legal    = (sel_len != 8'd0) && (sel_len <= 8'd4);
    assign next_ptr = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign win_oh   = NUM_REQ'(1) << win;
    assign owner_oh = NUM_REQ'(1) << owner;

`ifdef RC4_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner           <= '0;
            gnt             <= '0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            busy            <= 1'b0;
            core_start      <= 1'b0;
            core_key        <= '0;
            core_key_length <= '0;
`ifdef RC4_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            gnt        <= '0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner           <= win;
                        core_key        <= sel_key;
                        core_key_length <= sel_len;
                        gnt             <= win_oh;
                        busy            <= 1'b1;
                        if (legal) begin
                            core_start <= 1'b1;
                            state      <= RUN;
`ifdef RC4_TIMEOUT_EN
                            to_cnt     <= '0;
`endif
                        end else begin
                            // Bad length never reaches the core.
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= win_oh;
                            state     <= RESP;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_data  <= core_ks;
                        rsp_err   <= 1'b0;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
                    end
`ifdef RC4_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_core_arbiter.sv
// Scoreboard bench for rc4_core_arbiter: arbitration model, core model and response monitor.
module tb_rc4_core_arbiter;
    localparam int N     = 2;
    localparam int NB    = 4;
    localparam int TB_TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_key;
    logic [N*8-1:0]  req_key_length;
    logic [N-1:0]    gnt, rsp_valid, rsp_ready;
    logic [31:0]     rsp_data;
    logic            rsp_err, busy, core_start;
    logic [31:0]     core_key;
    logic [7:0]      core_key_length;
    logic            core_done, model_done, spur_done;
    logic [31:0]     core_ks;

    assign core_done = model_done | spur_done;

    always #5 clk = ~clk;

    rc4_core_arbiter #(.NUMS_OF_BYTES(NB), .NUM_REQ(N), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_key(req_key),
        .req_key_length(req_key_length), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .core_start(core_start), .core_key(core_key), .core_key_length(core_key_length),
        .core_done(core_done), .core_ks(core_ks)
    );

    typedef struct { int owner; logic [31:0] data; logic err; } exp_t;
    exp_t exp_q[$];
    int   gnt_log[$];

    int errors = 0, checks = 0;
    int ptr = 0, cur_owner = 0, cyc = 0, gnt_cyc = 0, n_start = 0;
    int active_jobs = 0, reset_gen = 0, fixed_delay = 0;
    bit hang_mode = 0, hang_job = 0, ready_hold = 0, use_fixed = 0, acc_pending = 0;
    bit done_prev = 0;
    logic [31:0]     fixed_ks = '0;
    logic [N-1:0]    prev_valid = '0, held_valid = '0, snap_req = '0;
    logic [N*32-1:0] snap_key = '0;
    logic [N*8-1:0]  snap_len = '0;
    logic [31:0]     held_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int predict(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Grant checking, reference arbitration and response scoreboard.
    always @(negedge clk) begin
        int w, o;
        logic [N-1:0] oh;
        logic [7:0] len;
        exp_t e;
        if (!rst_n) begin
            prev_valid = '0; acc_pending = 0; done_prev = 0; ptr = 0;
            hang_job = 0; exp_q.delete();
        end else begin
            cyc++;
            if (core_start || gnt != '0) begin
                chk("gnt_onehot", 64'($onehot(gnt)), 1);
                chk("busy_on_gnt", busy, 1);
                w = predict(snap_req, ptr);
                if (w < 0) begin
                    chk("gnt_without_req", gnt, 0);
                end else if ($onehot(gnt)) begin
                    oh = '0; oh[w] = 1'b1;
                    len = snap_len[8*w +: 8];
                    chk("gnt_winner", gnt, oh);
                    chk("core_key", core_key, snap_key[32*w +: 32]);
                    chk("core_key_length", core_key_length, len);
                    chk("core_start", core_start, (len >= 1 && len <= 4));
                    cur_owner = w; gnt_cyc = cyc; gnt_log.push_back(w);
                    if (!(len >= 1 && len <= 4)) exp_q.push_back('{w, 32'h0, 1'b1});
                    else begin
                        n_start++;
                        if (hang_mode) begin exp_q.push_back('{w, 32'h0, 1'b1}); hang_job = 1; end
                    end
                end
            end
            if (acc_pending) begin
                chk("rsp_valid_clear", rsp_valid, 0);
                chk("busy_after_accept", busy, 0);
                acc_pending = 0;
            end
            if (rsp_valid != '0) begin
                if (prev_valid == '0) begin
                    chk("rsp_onehot", 64'($onehot(rsp_valid)), 1);
                    o = 0;
                    for (int i = 0; i < N; i++) if (rsp_valid[i]) o = i;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_owner", o, e.owner);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", rsp_err, e.err);
                        if (!e.err) chk("done_to_valid", done_prev, 1);
                        if (e.err && hang_job) chk("timeout_cycles", cyc - gnt_cyc, TB_TO);
                        hang_job = 0;
                    end
                    held_data = rsp_data; held_valid = rsp_valid;
                end else begin
                    chk("rsp_data_stable", rsp_data, held_data);
                    chk("rsp_valid_stable", rsp_valid, held_valid);
                    chk("busy_in_resp", busy, 1);
                    chk("no_gnt_in_resp", gnt, 0);
                end
                for (int i = 0; i < N; i++)
                    if (rsp_valid[i] && rsp_ready[i]) begin ptr = (i + 1) % N; acc_pending = 1; end
            end
            prev_valid = rsp_valid; done_prev = core_done;
        end
        snap_req = req; snap_key = req_key; snap_len = req_key_length;
    end

    // Core model: answers each core_start after a delay with a keystream word.
    initial begin
        int g, d;
        bit aborted;
        logic [31:0] ks;
        model_done = 0; core_ks = '0;
        forever begin
            @(negedge clk);
            if (rst_n && core_start && !hang_mode) begin
                g = reset_gen; aborted = 0;
                d = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 20));
                for (int i = 0; i < d; i++) begin
                    @(posedge clk);
                    if (g != reset_gen) begin aborted = 1; break; end
                end
                #1;
                if (!aborted && g == reset_gen) begin
                    ks = use_fixed ? fixed_ks : $urandom;
                    core_ks = ks; model_done = 1;
                    exp_q.push_back('{cur_owner, ks, 1'b0});
                    @(posedge clk); #1;
                    model_done = 0; core_ks = $urandom;
                end
            end
        end
    end

    initial begin
        rsp_ready = '0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = ready_hold ? '0 : N'($urandom);
        end
    end

    task automatic do_job(input int r, input logic [31:0] key, input logic [7:0] len, input bit keep);
        int t;
        active_jobs++;
        @(posedge clk); #1;
        req_key[32*r +: 32] = key; req_key_length[8*r +: 8] = len; req[r] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!gnt[r] && t < 5000);
        if (!gnt[r]) chk("gnt_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) req[r] = 1'b0;
        active_jobs--;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!(busy == 1'b0 && rsp_valid == '0 && exp_q.size() == 0 && active_jobs == 0) && t < 20000);
        if (t >= 20000) chk("idle_timeout", 0, 1);
    endtask

    task automatic pulse_spur();
        @(posedge clk); #1 spur_done = 1;
        @(posedge clk); #1 spur_done = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_key"}, core_key, 0);
        chk({tag, "_core_key_length"}, core_key_length, 0);
    endtask

    initial begin
        int n0, t;
        req = '0; req_key = '0; req_key_length = '0; spur_done = 0;
        rst_n = 1; #3 rst_n = 0; #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;

        // Single job with fixed key and keystream, slow core.
        n0 = n_start; gnt_log.delete();
        fixed_delay = 300; use_fixed = 1; fixed_ks = 32'hA1B2C3D4;
        do_job(0, 32'h40302010, 8'd4, 0);
        wait_idle();
        chk("t1_starts", n_start - n0, 1);
        chk("t1_gnt_count", gnt_log.size(), 1);
        use_fixed = 0; fixed_delay = 0;

        // Spurious core_done while idle must do nothing.
        pulse_spur();
        repeat (3) @(negedge clk);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_valid", rsp_valid, 0);

        // Pointer moves to 0 after serving requester 1.
        do_job(1, $urandom, 8'd2, 0);
        wait_idle();

        // Contention: both hold req across three jobs each.
        gnt_log.delete();
        fork
            begin for (int j = 0; j < 3; j++) do_job(0, $urandom, 8'($urandom_range(1, 4)), j < 2); end
            begin for (int j = 0; j < 3; j++) do_job(1, $urandom, 8'($urandom_range(1, 4)), j < 2); end
        join
        wait_idle();
        chk("t2_gnt_count", gnt_log.size(), 6);
        for (int j = 0; j < 6 && j < gnt_log.size(); j++) chk("t2_gnt_order", gnt_log[j], j % 2);

        // Illegal lengths.
        n0 = n_start;
        do_job(0, $urandom, 8'd0, 0); wait_idle();
        do_job(1, $urandom, 8'd5, 0); wait_idle();
        do_job(0, $urandom, 8'hFF, 0); wait_idle();
        chk("t3_no_start", n_start - n0, 0);

        // Backpressure with spurious done in RESP and a competing request.
        gnt_log.delete(); ready_hold = 1; fixed_delay = 10;
        fork
            do_job(0, $urandom, 8'd3, 0);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!rsp_valid[0] && t < 1000);
                fork do_job(1, $urandom, 8'd1, 0); join_none
                repeat (5) @(posedge clk);
                pulse_spur();
                repeat (15) @(posedge clk);
                #1 ready_hold = 0;
            end
        join
        wait_idle();
        fixed_delay = 0;
        chk("t4_gnt_count", gnt_log.size(), 2);

        // Reset in the middle of RUN.
        fixed_delay = 50;
        do_job(0, $urandom, 8'd4, 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 0; reset_gen++;
        #1 chk_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        fixed_delay = 0; gnt_log.delete();
        do_job(1, $urandom, 8'd4, 0);
        wait_idle();
        chk("t5_gnt_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) chk("t5_gnt_owner", gnt_log[0], 1);

`ifdef RC4_TIMEOUT_EN
        // Core never answers; late done during RESP is ignored.
        hang_mode = 1; ready_hold = 1;
        do_job(0, $urandom, 8'd4, 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!rsp_valid[0] && t < 1000);
        pulse_spur();
        repeat (3) @(posedge clk);
        #1 ready_hold = 0;
        wait_idle();
        hang_mode = 0;
`endif

        // Random jobs from both requesters, legal and illegal lengths.
        fork
            begin for (int j = 0; j < 5; j++) do_job(0, $urandom, 8'($urandom_range(0, 6)), 0); end
            begin for (int j = 0; j < 5; j++) do_job(1, $urandom, 8'($urandom_range(0, 6)), 0); end
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rc4_core_arbiter.md
Name: rc4_core_arbiter

Overview:
Round-robin arbiter and sequencer that shares one rc4_new_design keystream core between NUM_REQ requesters. It accepts a key job from one requester, loads the key and length into the core, and pulses start. It then waits for done, captures the keystream word and returns it to the owning requester over a valid/ready response. It sits between the requester blocks and the single RC4 core instance.

Parameters:
NUMS_OF_BYTES, 4, keystream bytes per job; must match the core's NUMS_OF_BYTES.
NUM_REQ, 2, number of requesters (2..8).
TIMEOUT_CYCLES, 4096, watchdog limit in RUN; used only with RC4_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  per-requester job request; held with key fields until gnt.
req_key  in  NUM_REQ*32  per-requester key; slice r = [32r+31:32r].
req_key_length  in  NUM_REQ*8  per-requester key length in bytes.
gnt  out  NUM_REQ  one-hot, one-cycle pulse; the job has been accepted.
rsp_valid  out  NUM_REQ  one-hot; the response is held for the owning requester.
rsp_ready  in  NUM_REQ  per-requester response accept.
rsp_data  out  NUMS_OF_BYTES*8  keystream word; stable while any rsp_valid bit is 1.
rsp_err  out  1  response error flag; qualified by rsp_valid.
busy  out  1  high in every state except IDLE.
core_start  out  1  one-cycle start pulse to the core.
core_key  out  32  key to the core, registered.
core_key_length  out  8  key length to the core, registered.
core_done  in  1  core completion pulse.
core_ks  in  NUMS_OF_BYTES*8  core keystream word; valid in the cycle core_done=1.

Behaviour:
- Reset values (asynchronous, with rst_n=0): gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, core_start=0, core_key=0, core_key_length=0, state=IDLE, rr_ptr=0, owner=0.
- States: IDLE, RUN, RESP.
- Arbitration (IDLE):
  - Search starts at index rr_ptr and wraps modulo NUM_REQ; the first r with req[r]=1 wins.
  - In the cycle of the winning edge: latch owner=r, core_key and core_key_length from the owner's slices, and pulse gnt[r] for that cycle.
- Key-length check:
  - Legal lengths are 1..4.
  - Legal length: core_start=1 in the same cycle as gnt; go to RUN.
  - Length 0 or >4: no core_start; rsp_err=1, rsp_data=0; go directly to RESP.
- RUN:
  - Wait for core_done=1. On that edge: rsp_data<=core_ks, rsp_err<=0, rsp_valid[owner]<=1; go to RESP.
  - Latency from the arbitration edge to rsp_valid is (core run time + 1) cycles.
- RESP:
  - rsp_valid[owner] holds with rsp_data stable until rsp_ready[owner]=1 is sampled.
  - On that edge: rsp_valid<=0, rr_ptr<=(owner+1) mod NUM_REQ; go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Fairness and back-to-back jobs:
  - A requester still asserting req on return to IDLE starts a new job.
  - The rotating pointer guarantees every other pending requester is served first.
  - Minimum idle gap between jobs is 1 cycle (the IDLE arbitration cycle).
- core_done outside RUN (IDLE, RESP) is ignored; no state or output change.
- req deasserted before gnt: the request is withdrawn and never served.
- Simultaneous requests: only one gnt bit per cycle; losers must keep req high.
- Reset mid-job: immediate return to reset values; the core shares rst_n; no response is issued for the aborted job.

Optional Feature:
- Macro: RC4_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to RUN and increments each cycle in RUN.
  - When it reaches TIMEOUT_CYCLES-1 with no core_done: rsp_err=1, rsp_data=0, rsp_valid[owner]=1; go to RESP.
  - A later core_done for that job is ignored.
  - core_done and expiry in the same cycle: core_done wins, so rsp_err=0.
- Undefined: no counter exists, and RUN waits for core_done indefinitely.

Test Plan:
1. Single job: req[0]=1, key 0x40302010, length 4; core model gives done 300 cycles later with ks 0xA1B2C3D4 -> exactly one gnt[0] pulse and one core_start pulse, core_key=0x40302010, core_key_length=4; rsp_valid[0] rises 1 cycle after done with rsp_data=0xA1B2C3D4, rsp_err=0; rsp_valid[0] clears 1 cycle after rsp_ready[0].
2. Contention: req[0] and req[1] held high over 3 jobs each -> grant order 0,1,0,1,0,1; never two gnt bits at once.
3. Illegal length 0 and then 5 -> no core_start; rsp_valid with rsp_err=1, rsp_data=0.
4. Backpressure: rsp_ready low for 20 cycles, plus a spurious core_done during RESP -> rsp_data stable, busy=1, no new gnt until ready.
5. Reset mid-RUN: rst_n=0 for 2 cycles -> all outputs 0 asynchronously; the next req[1] is served normally with rr_ptr=0.
6. With RC4_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never done -> rsp_err=1 exactly 16 cycles after the arbitration edge; a late core_done is ignored.
